// File: rtl/irq_exception_controller.sv
// Prioritised interrupt controller: picks the highest-priority eligible IRQ, presents its vector,
// and tracks acceptance, service and ack timeout.
module irq_exception_controller #(
  parameter logic [7:0] VECTOR_BASE = 8'd64,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IRQ_req,
  input  logic [63:0] IPR_data,
  input  logic [3:0]  cpu_mask,
  input  logic        cpu_ack,
  input  logic        exception_done,
  output logic        int_req,
  output logic [7:0]  int_vector,
  output logic [3:0]  int_level,
  output logic [15:0] irq_clr,
  output logic        interrupt_exception_handling,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_int_req, w_int_req_nxt;
  logic [7:0]  r_vec, w_vec_nxt;
  logic [3:0]  r_lvl, w_lvl_nxt;
  logic [15:0] r_clr, w_clr_nxt;
  logic        r_ieh, w_ieh_nxt;
  logic        r_terr, w_terr_nxt;

  logic        w_any;
  logic [3:0]  w_win_idx;
  logic [3:0]  w_win_prio;

  // Strictly-greater compare while scanning upward keeps the lowest index on ties.
  always_comb begin
    w_any      = 1'b0;
    w_win_idx  = '0;
    w_win_prio = '0;
    for (int n = 0; n < 16; n++) begin
      if (IRQ_req[n] && (IPR_data[4*n +: 4] > cpu_mask) &&
          (IPR_data[4*n +: 4] > w_win_prio)) begin
        w_any      = 1'b1;
        w_win_idx  = 4'(n);
        w_win_prio = IPR_data[4*n +: 4];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_int_req_nxt = r_int_req;
    w_vec_nxt     = r_vec;
    w_lvl_nxt     = r_lvl;
    w_clr_nxt     = '0;
    w_ieh_nxt     = r_ieh;
    w_terr_nxt    = r_terr;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt   = S_REQ;
          w_idx_nxt     = w_win_idx;
          w_cnt_nxt     = '0;
          w_int_req_nxt = 1'b1;
          w_vec_nxt     = VECTOR_BASE + {4'd0, w_win_idx};
          w_lvl_nxt     = w_win_prio;
        end
      end
      S_REQ: begin
        // Ack beats both timeout and withdrawal in the same cycle.
        if (cpu_ack) begin
          w_state_nxt       = S_SERVICE;
          w_int_req_nxt     = 1'b0;
          w_clr_nxt[r_idx]  = 1'b1;
          w_ieh_nxt         = 1'b1;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt   = S_IDLE;
          w_int_req_nxt = 1'b0;
          w_terr_nxt    = 1'b1;
        end else if (!IRQ_req[r_idx]) begin
          w_state_nxt   = S_IDLE;
          w_int_req_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_SERVICE: begin
        if (exception_done) begin
          w_state_nxt = S_IDLE;
          w_ieh_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_int_req <= 1'b0;
      r_vec     <= '0;
      r_lvl     <= '0;
      r_clr     <= '0;
      r_ieh     <= 1'b0;
      r_terr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_int_req <= w_int_req_nxt;
      r_vec     <= w_vec_nxt;
      r_lvl     <= w_lvl_nxt;
      r_clr     <= w_clr_nxt;
      r_ieh     <= w_ieh_nxt;
      r_terr    <= w_terr_nxt;
    end
  end

  assign int_req                      = r_int_req;
  assign int_vector                   = r_vec;
  assign int_level                    = r_lvl;
  assign irq_clr                      = r_clr;
  assign interrupt_exception_handling = r_ieh;
  assign timeout_err                  = r_terr;

endmodule

// File: doc/irq_exception_controller.md
IRQ_EXCEPTION_CONTROLLER -- requirements
Module: irq_exception_controller

Interface
REQ-001 Parameter VECTOR_BASE, default 8'd64: vector number issued for IRQ0; IRQn issues VECTOR_BASE+n.
REQ-002 Parameter ACK_TIMEOUT, default 255: REQ-state cycles without cpu_ack before request is withdrawn; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 IRQ_req  input  16  enabled pending requests from IRQn input unit, bit n = IRQn, level-sensitive.
REQ-006 IPR_data  input  64  priority of IRQn in bits [4n+3:4n], 0 = never serviced, 15 = highest.
REQ-007 cpu_mask  input  4  CPU interrupt mask level; only priorities strictly greater are eligible.
REQ-008 cpu_ack  input  1  CPU acceptance of the presented vector, single-cycle pulse.
REQ-009 exception_done  input  1  CPU end of exception handling (RTE), single-cycle pulse.
REQ-010 int_req  output  1  interrupt request to CPU.
REQ-011 int_vector  output  8  vector number, valid while int_req=1.
REQ-012 int_level  output  4  priority of presented request, valid while int_req=1.
REQ-013 irq_clr  output  16  one-hot clear pulse to the IRQn input unit.
REQ-014 interrupt_exception_handling  output  1  high while accepted exception is in service.
REQ-015 timeout_err  output  1  sticky flag: an ack timeout occurred.

Function
REQ-016 Eligible(n) = IRQ_req[n] & (IPR priority of n > cpu_mask); priority 0 never eligible.
REQ-017 Winner = eligible request with highest priority; ties resolved to lowest index n.
REQ-018 FSM states: IDLE, REQ, SERVICE; all outputs registered.
REQ-019 IDLE: on an edge with any eligible request, latch winner index/priority, go REQ; int_req rises at that same edge (one-cycle latency from request visibility).
REQ-020 REQ: int_req=1; int_vector=VECTOR_BASE+winner (8-bit wrap); int_level=winner priority; both held stable, no re-arbitration even if a higher request arrives.
REQ-021 REQ + cpu_ack: next edge int_req=0, irq_clr[winner]=1 for exactly one cycle, interrupt_exception_handling=1, go SERVICE.
REQ-022 REQ, no ack, IRQ_req[winner]=0: withdraw -- next edge int_req=0, no irq_clr, go IDLE.
REQ-023 cpu_ack and withdrawal in same cycle: cpu_ack wins (REQ-021).
REQ-024 8-bit wait counter clears on entry to REQ, increments each REQ cycle without ack; reaching ACK_TIMEOUT: int_req=0, timeout_err=1, no irq_clr, go IDLE.
REQ-025 timeout_err clears only on rst.
REQ-026 SERVICE: int_req=0; new requests ignored; on exception_done -> IDLE, interrupt_exception_handling=0 at same edge.
REQ-027 exception_done outside SERVICE and cpu_ack outside REQ are ignored.
REQ-028 After SERVICE->IDLE, arbitration resumes the following cycle; minimum one IDLE cycle between services.
REQ-029 irq_clr is all-zero in every cycle except the REQ-021 pulse; never more than one bit set.

Reset
REQ-030 rst asserted: immediately state=IDLE, int_req=0, int_vector=0, int_level=0, irq_clr=0, interrupt_exception_handling=0, timeout_err=0, counter=0.
REQ-031 rst mid-REQ or mid-SERVICE aborts without any irq_clr pulse; first arbitration at first edge after rst deassertion.

Verification
REQ-032 IRQ_req=16'h0020, IRQ5 prio 7, cpu_mask=3 -> int_req next edge, int_vector=69, int_level=7; cpu_ack -> irq_clr=16'h0020 one cycle, interrupt_exception_handling=1; exception_done -> IDLE.
REQ-033 IRQ2 and IRQ9 both prio 10, IRQ4 prio 12, all pending -> vector 68 first; after service IRQ4 cleared, vector 66 next.
REQ-034 IRQ3 prio 4, cpu_mask=4 -> int_req stays 0; cpu_mask=3 -> int_req next edge.
REQ-035 ACK_TIMEOUT=4, no cpu_ack -> int_req drops after 4 REQ cycles, timeout_err=1, irq_clr stays 0.
REQ-036 IRQ_req[winner] drops before ack -> int_req falls next edge, no irq_clr; same-cycle drop+ack -> irq_clr pulse issued.
REQ-037 rst pulsed during SERVICE -> all outputs 0 immediately, no irq_clr, re-arbitration after release.
